// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester, transmitter and status signals of the UART TX arbiter
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic                   baud_tick;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     gnt;
  logic                   tx_send;
  logic [7:0]             tx_data;
  logic                   tx_done;
  logic                   busy;
  logic [2:0]             cur_id;
  logic                   err_timeout;
  modport master (output baud_tick, req, req_data, tx_done,
                  input gnt, tx_send, tx_data, busy, cur_id, err_timeout);
  modport slave (input baud_tick, req, req_data, tx_done,
                 output gnt, tx_send, tx_data, busy, cur_id, err_timeout);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with inter-frame gap and frame watchdog
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 16
) (
  input logic clk,
  input logic rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int CW = $clog2(GAP_TICKS > TIMEOUT_TICKS ? GAP_TICKS : TIMEOUT_TICKS) + 1;
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;
  state_t state, state_n, after_frame;
  logic [2:0] ptr, ptr_n, cur, cur_n, win;
  logic [3:0] d, best;
  logic [7:0] data, data_n, win_data;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [NUM_REQ-1:0] gnt, gnt_n;
  logic send, send_n, err, err_n;
  assign bus.gnt         = gnt;
  assign bus.tx_send     = send;
  assign bus.tx_data     = data;
  assign bus.busy        = state != IDLE;
  assign bus.cur_id      = cur;
  assign bus.err_timeout = err;
  assign after_frame     = GAP_TICKS > 0 ? GAP : IDLE;
  assign cnt_inc         = &cnt ? cnt : cnt + 1'b1;
  // d is each requester's distance after ptr; the nearest pending one wins
  always_comb begin
    win = ptr;
    win_data = '0;
    best = 4'(NUM_REQ);
    d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = 4'((i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ);
      if (bus.req[i] && d < best) begin
        best = d;
        win = 3'(i);
        win_data = bus.req_data[8*i +: 8];
      end
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cur_n = cur;
    data_n = data;
    cnt_n = cnt;
    gnt_n = '0;
    send_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (|bus.req) begin
        state_n = WAIT_DONE;
        gnt_n = NUM_REQ'(1) << win;
        send_n = 1'b1;
        data_n = win_data;
        cur_n = win;
        ptr_n = win;
        cnt_n = '0;
      end
      WAIT_DONE: if (bus.tx_done) begin
        state_n = after_frame;
        cnt_n = '0;
      end else if (bus.baud_tick && cnt == TO_LAST) begin
        state_n = after_frame;
        cnt_n = '0;
        err_n = 1'b1;
      end else if (bus.baud_tick) begin
        cnt_n = cnt_inc;
      end
      GAP: if (bus.baud_tick) begin
        state_n = cnt == GAP_LAST ? IDLE : GAP;
        cnt_n = cnt == GAP_LAST ? '0 : cnt_inc;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 3'(NUM_REQ - 1);
      cur <= '0;
      data <= '0;
      cnt <= '0;
      gnt <= '0;
      send <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cur <= cur_n;
      data <= data_n;
      cnt <= cnt_n;
      gnt <= gnt_n;
      send <= send_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a round-robin reference model and a transmitter model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int GAP = 1;
  localparam int TMO = 16;
  typedef struct {int id; logic [7:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus0 ();
  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  uart_tx_arbiter #(.NUM_REQ(N), .GAP_TICKS(0), .TIMEOUT_TICKS(TMO)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  int checks = 0, fails = 0;
  exp_t sb[$];
  int err_q[$];
  int rr_ptr = N - 1;
  int tx_mode = 0;
  logic [7:0] dat[N];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // next requester after ptr, searching ptr+1, ptr+2, ... modulo N
  function automatic int rr_pick(int p, logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  initial begin
    bus.baud_tick = 1'b0;
    bus0.baud_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.baud_tick = 1'b1;
      bus0.baud_tick = 1'b1;
      @(posedge clk);
      #1 bus.baud_tick = 1'b0;
      bus0.baud_tick = 1'b0;
    end
  end
  // transmitter model: mode 0 finishes after 10..12 ticks, 1 never finishes, 2 finishes on tick 16
  int n1, k1;
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_send && tx_mode != 1) begin
        n1 = tx_mode == 2 ? TMO : int'($urandom_range(10, 12));
        k1 = bus.baud_tick ? 1 : 0;
        while (k1 < n1 && !rst) begin
          @(posedge clk);
          #2 if (bus.baud_tick) k1++;
        end
        if (!rst) begin
          bus.tx_done = 1'b1;
          @(posedge clk);
          #2 bus.tx_done = 1'b0;
        end
      end
    end
  end
  int k0;
  initial begin
    bus0.tx_done = 1'b0;
    bus0.req = 4'b0011;
    bus0.req_data = {16'h0000, 8'hAA, 8'h55};
    forever begin
      @(negedge clk);
      if (bus0.tx_send) begin
        k0 = bus0.baud_tick ? 1 : 0;
        while (k0 < 10 && !rst) begin
          @(posedge clk);
          #2 if (bus0.baud_tick) k0++;
        end
        if (!rst) begin
          bus0.tx_done = 1'b1;
          @(posedge clk);
          #2 bus0.tx_done = 1'b0;
        end
      end
    end
  end
  int t = 0, g = 0;
  bit gap_on = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int ee;
    if (!rst) begin
      if (bus.err_timeout) begin
        if (err_q.size() == 0) chk("unexpected_err", 32'(bus.err_timeout), 32'(0));
        else begin
          ee = err_q.pop_front();
          chk("timeout_ticks", 32'(t), 32'(ee));
        end
        g = 0;
        gap_on = 1'b1;
      end
      if (bus.tx_send || |bus.gnt) begin
        if (sb.size() == 0) chk("unexpected_gnt", 32'(bus.gnt), 32'(0));
        else begin
          e = sb.pop_front();
          chk("gnt_send", 32'({bus.tx_send, bus.gnt}), 32'({1'b1, N'(1) << e.id}));
          chk("tx_data", 32'(bus.tx_data), 32'(e.data));
          chk("cur_id", 32'(bus.cur_id), 32'(e.id));
        end
        t = 0;
      end
      if (gap_on && !bus.busy) begin
        chk("gap_ticks", 32'(g), 32'(GAP));
        gap_on = 1'b0;
      end
      if (bus.baud_tick) begin
        t++;
        g++;
      end
      if (bus.tx_done && bus.busy) begin
        g = 0;
        gap_on = 1'b1;
      end
    end
  end
  // back-to-back instance: relaunch one clk after tx_done is taken, alternating 0,1
  int dsince = -1, p0 = N - 1, frames0 = 0, w0;
  always @(negedge clk) begin
    if (rst) begin
      dsince = -1;
      p0 = N - 1;
    end else begin
      if (bus0.err_timeout) chk("gap0_err", 32'(bus0.err_timeout), 32'(0));
      if (bus0.tx_send) begin
        w0 = rr_pick(p0, 4'b0011);
        p0 = w0;
        frames0++;
        chk("gap0_id", 32'(bus0.cur_id), 32'(w0));
        chk("gap0_data", 32'(bus0.tx_data), 32'(w0 == 0 ? 8'h55 : 8'hAA));
        if (dsince >= 0) chk("gap0_relaunch", 32'(dsince), 32'(1));
        dsince = -1;
      end
      if (bus0.tx_done) dsince = 0;
      else if (dsince >= 0) dsince++;
    end
  end
  task automatic wait_idle();
    int c = 0;
    while (bus.busy && c < 500) begin
      @(posedge clk);
      #1 c++;
    end
    if (bus.busy) chk("idle_wait", 32'(bus.busy), 32'(0));
  endtask
  task automatic wait_gnt();
    int c = 0;
    while (!(|bus.gnt) && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
    if (!(|bus.gnt)) chk("gnt_wait", 32'(|bus.gnt), 32'(1));
  endtask
  task automatic drive(logic [N-1:0] m, int mode);
    for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = dat[i];
    bus.req = m;
    tx_mode = mode;
  endtask
  task automatic expect_grant(logic [N-1:0] m, int mode);
    int w;
    w = rr_pick(rr_ptr, m);
    rr_ptr = w;
    sb.push_back('{w, dat[w]});
    if (mode == 1) err_q.push_back(TMO);
  endtask
  task automatic issue(logic [N-1:0] m, int mode);
    wait_idle();
    @(posedge clk);
    #1 drive(m, mode);
    expect_grant(m, mode);
    wait_gnt();
    @(posedge clk);
    #1 bus.req = '0;
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    #12;
    chk("reset_state", 32'({bus.busy, bus.gnt, bus.tx_send, bus.tx_data, bus.cur_id, bus.err_timeout}), 32'(0));
    chk("reset_state0", 32'({bus0.busy, bus0.gnt, bus0.tx_send, bus0.tx_data, bus0.cur_id}), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    dat[0] = 8'hA5;
    issue(4'b0001, 0);
    wait_idle();
    @(posedge clk);
    #1 for (int i = 0; i < N; i++) dat[i] = 8'(8'h10 + i);
    drive(4'b1111, 0);
    for (int f = 0; f < 5; f++) expect_grant(4'b1111, 0);
    for (int f = 0; f < 5; f++) begin
      wait_gnt();
      @(posedge clk);
      #1;
    end
    bus.req = '0;
    issue(4'b0100, 0);
    issue(4'b0101, 0);
    issue(4'b0100, 0);
    issue(4'b0010, 1);
    issue(4'b0001, 0);
    issue(4'b0100, 2);
    wait_idle();
    dat[0] = 8'h3C;
    issue(4'b0001, 0);
    repeat (12) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset", 32'({bus.busy, bus.gnt, bus.tx_send, bus.tx_data, bus.cur_id, bus.err_timeout}), 32'(0));
    rr_ptr = N - 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    dat[3] = 8'h77;
    issue(4'b1000, 0);
    for (int r = 0; r < 30; r++) begin
      int sel;
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      issue(N'($urandom_range(1, 15)), sel == 0 ? 1 : sel == 1 ? 2 : 0);
    end
    wait_idle();
    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    chk("err_q_drained", 32'(err_q.size()), 32'(0));
    chk("gap0_frames", 32'(frames0 >= 3), 32'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
